latch_q_debounce: RTL

Downstream consumer of the 2:1-MUX D latch output `q`. It synchronises the latch output into the clock domain and debounces it by requiring N consecutive stable samples. It then emits a clean level, single-cycle rise/fall pulses, and saturating counters for accepted edges and rejected glitches. It converts the transparent-latch output into a glitch-free, edge-qualified signal for downstream synchronous logic.

---
 rtl/latch_q_debounce.sv | 133 +++++++++++++
 1 files changed

// File: rtl/latch_q_debounce.sv
// ============================================================================
// latch_q_debounce: synchronises and debounces a transparent-latch output,
// producing a clean level, edge pulses and saturating edge/glitch counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module latch_q_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             q_in,
  input  logic             clear,
  output logic             q_clean,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] glitch_count
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  localparam logic [7:0]       c_stab_last = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             q_clean_q, q_clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic             w_commit;
  logic             w_glitch;

  always_comb begin
    state_d      = state_q;
    stab_cnt_d   = stab_cnt_q;
    q_clean_d    = q_clean_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    edge_cnt_d   = edge_cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    w_commit     = 1'b0;
    w_glitch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2_q != q_clean_q) begin
          if (STABLE_CYCLES == 1) begin
            w_commit = 1'b1;
          end else begin
            stab_cnt_d = 8'd1;
            state_d    = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (s2_q == q_clean_q) begin
          w_glitch = 1'b1;
          state_d  = IDLE;
        end else if (stab_cnt_q == c_stab_last) begin
          w_commit = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_commit) begin
      q_clean_d = s2_q;
      rise_d    = s2_q;
      fall_d    = ~s2_q;
      state_d   = IDLE;
    end

    // clear wins over a same-cycle increment; counters stick at all-ones
    if (clear) begin
      edge_cnt_d   = '0;
      glitch_cnt_d = '0;
    end else begin
      if (w_commit && (edge_cnt_q != c_cnt_max)) begin
        edge_cnt_d = edge_cnt_q + c_cnt_one;
      end
      if (w_glitch && (glitch_cnt_q != c_cnt_max)) begin
        glitch_cnt_d = glitch_cnt_q + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= IDLE;
      stab_cnt_q   <= 8'd0;
      q_clean_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      edge_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      s1_q         <= q_in;
      s2_q         <= s1_q;
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      q_clean_q    <= q_clean_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      edge_cnt_q   <= edge_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign q_clean      = q_clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign busy         = (state_q == QUALIFY);
  assign edge_count   = edge_cnt_q;
  assign glitch_count = glitch_cnt_q;

endmodule

`default_nettype wire
